// File: rtl/core_pkg.sv
// Shared types for the fetch-stage controller: FSM states, 2-bit saturating
// counters and the BTB entry layout.
package core_pkg;

  localparam int XLEN = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } fsm_state_e;

  typedef logic [1:0] sat_ctr_t;

  localparam sat_ctr_t SAT_MAX   = 2'b11;
  localparam sat_ctr_t SAT_MIN   = 2'b00;
  localparam sat_ctr_t CTR_ALLOC = 2'b10;

  // Tag is kept at full width; the unused upper bits are always zero.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target;
    sat_ctr_t        ctr;
  } btb_entry_t;

  function automatic sat_ctr_t ctr_next(input sat_ctr_t ctr, input logic taken);
    if (taken) return (ctr == SAT_MAX) ? SAT_MAX : ctr + 2'd1;
    else       return (ctr == SAT_MIN) ? SAT_MIN : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch/resolve bus between the pipeline (master) and fetch_ctrl (slave).
interface fetch_ctrl_if;
  import core_pkg::*;

  logic [XLEN-1:0] pc;
  logic            imem_ready;
  logic            hazard_stall;
  logic            halt_req;
  logic            res_valid;
  logic [XLEN-1:0] res_pc;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            res_pred_taken;
  logic [XLEN-1:0] res_pred_adr;
  logic [XLEN-1:0] res_pcinc;
  logic            jump_pred;
  logic [XLEN-1:0] jump_pred_adr;
  logic            jump_pred_miss;
  logic            jump_pred_adr_miss;
  logic [XLEN-1:0] pcinc_evac;
  logic            en_pc;
  logic            flush;
  logic            halted;
  logic [XLEN-1:0] miss_count;

  modport master (
    output pc, imem_ready, hazard_stall, halt_req, res_valid, res_pc, res_taken,
           res_target, res_pred_taken, res_pred_adr, res_pcinc,
    input  jump_pred, jump_pred_adr, jump_pred_miss, jump_pred_adr_miss,
           pcinc_evac, en_pc, flush, halted, miss_count
  );

  modport slave (
    input  pc, imem_ready, hazard_stall, halt_req, res_valid, res_pc, res_taken,
           res_target, res_pred_taken, res_pred_adr, res_pcinc,
    output jump_pred, jump_pred_adr, jump_pred_miss, jump_pred_adr_miss,
           pcinc_evac, en_pc, flush, halted, miss_count
  );

endinterface

// File: rtl/fetch_ctrl_btb.sv
// Direct-mapped branch target buffer with 2-bit counters: one combinational
// lookup port for fetch and one training port for resolved branches.
module btb
  import core_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_hit,
    output logic            lookup_taken,
    output logic [XLEN-1:0] lookup_target,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    btb_entry_t mem [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [XLEN-1:0]  lk_tag, up_tag;
    logic             up_hit;

    assign lk_idx = lookup_pc[IDX_W-1:0];
    assign up_idx = upd_pc[IDX_W-1:0];
    assign lk_tag = lookup_pc >> IDX_W;
    assign up_tag = upd_pc >> IDX_W;

    // Reads come straight off the registered array, so a same-cycle update is
    // only visible to the lookup from the next cycle on.
    assign lookup_hit    = mem[lk_idx].valid && (mem[lk_idx].tag == lk_tag);
    assign lookup_taken  = lookup_hit && mem[lk_idx].ctr[1];
    assign lookup_target = mem[lk_idx].target;
    assign up_hit        = mem[up_idx].valid && (mem[up_idx].tag == up_tag);

    // NOTE: the array is reset entry by entry because a cold BTB must never
    // predict; a storage array without that requirement would be left unreset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) mem[i] <= '0;
        end else if (upd_en) begin
            if (up_hit) begin
                mem[up_idx].ctr <= ctr_next(mem[up_idx].ctr, upd_taken);
                if (upd_taken) mem[up_idx].target <= upd_target;
            end else if (upd_taken) begin
                mem[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target,
                                 ctr: CTR_ALLOC};
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: run/stall/halt FSM, misprediction decode and
// redirect, pc enable, flush and a saturating misprediction counter.
module fetch_ctrl
  import core_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input logic         clk,
    input logic         reset,
    fetch_ctrl_if.slave bus
);

    localparam logic [1:0] RUN   = 2'(ST_RUN);
    localparam logic [1:0] STALL = 2'(ST_STALL);
    localparam logic [1:0] HALT  = 2'(ST_HALT);

    logic [1:0]      state, state_nxt;
    logic            active, pmiss_raw, amiss_raw, any_miss, pmiss, amiss;
    logic            stall_cause, upd_en;
    logic            lk_hit, lk_taken;
    logic [XLEN-1:0] lk_target;

    assign active      = bus.res_valid && (state != HALT);
    assign pmiss_raw   = active && bus.res_pred_taken && !bus.res_taken;
    assign amiss_raw   = active && bus.res_taken &&
                         (!bus.res_pred_taken || (bus.res_pred_adr != bus.res_target));
    assign any_miss    = pmiss_raw || amiss_raw;
    // A halt in MEM outranks the redirect: the wrong path is still flushed
    // but fetch is not redirected and the miss is not reported.
    assign pmiss       = pmiss_raw && !bus.halt_req;
    assign amiss       = amiss_raw && !bus.halt_req;
    assign stall_cause = bus.hazard_stall || !bus.imem_ready;
    assign upd_en      = active && !bus.halt_req;

    btb #(.BTB_ENTRIES(BTB_ENTRIES), .IDX_W(IDX_W)) u_btb (
        .clk          (clk),
        .reset        (reset),
        .lookup_pc    (bus.pc),
        .lookup_hit   (lk_hit),
        .lookup_taken (lk_taken),
        .lookup_target(lk_target),
        .upd_en       (upd_en),
        .upd_pc       (bus.res_pc),
        .upd_taken    (bus.res_taken),
        .upd_target   (bus.res_target)
    );

    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        bus.en_pc = 1'b0;
        if (state == HALT || bus.halt_req) begin
            state_nxt = HALT;
        end else if (any_miss) begin
            bus.en_pc = 1'b1;
            state_nxt = stall_cause ? STALL : RUN;
        end else begin
            bus.en_pc = (state == RUN) && !stall_cause;
            state_nxt = stall_cause ? STALL : RUN;
        end
    end

    assign bus.jump_pred          = lk_hit && lk_taken && !any_miss && (state != HALT);
    assign bus.jump_pred_adr      = lk_target;
    assign bus.jump_pred_miss     = pmiss;
    assign bus.jump_pred_adr_miss = amiss;
    assign bus.flush              = any_miss;
    assign bus.pcinc_evac         = bus.res_pcinc;
    assign bus.halted             = (state == HALT);

    // NOTE: registers are written with non-blocking assignments so every
    // always_ff samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            bus.miss_count <= '0;
        end else begin
            state <= state_nxt;
            if ((pmiss || amiss) && (bus.miss_count != 16'hFFFF))
                bus.miss_count <= bus.miss_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl: the stimulus thread queues the
// hand-computed response per cycle, a monitor thread compares at negedge.
module tb_fetch_ctrl;
  import core_pkg::*;

  typedef struct {
    logic [15:0] pc;
    logic        imem_ready, hazard_stall, halt_req;
    logic        res_valid, res_taken, res_pred_taken;
    logic [15:0] res_pc, res_target, res_pred_adr, res_pcinc;
  } stim_t;

  typedef struct {
    string       name;
    logic        jp, jpm, jpam, en, fl, hlt;
    logic [15:0] cnt;
    logic        chk_jpa, chk_evac;
    logic [15:0] jpa, evac;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   stim_done = 1'b0;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.BTB_ENTRIES(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic stim_t idle(input logic [15:0] pc);
    stim_t s;
    s.pc = pc; s.imem_ready = 1'b1; s.hazard_stall = 1'b0; s.halt_req = 1'b0;
    s.res_valid = 1'b0; s.res_taken = 1'b0; s.res_pred_taken = 1'b0;
    s.res_pc = '0; s.res_target = '0; s.res_pred_adr = '0; s.res_pcinc = '0;
    return s;
  endfunction

  function automatic stim_t resolve(input logic [15:0] pc, rpc, input logic taken,
                                    input logic [15:0] target, input logic pt,
                                    input logic [15:0] padr);
    stim_t s = idle(pc);
    s.res_valid = 1'b1; s.res_pc = rpc; s.res_taken = taken; s.res_target = target;
    s.res_pred_taken = pt; s.res_pred_adr = padr; s.res_pcinc = rpc + 16'd1;
    return s;
  endfunction

  function automatic exp_t mk(input string name, input logic jp, jpm, jpam, en, fl, hlt,
                              input logic [15:0] cnt);
    exp_t e;
    e.name = name; e.jp = jp; e.jpm = jpm; e.jpam = jpam; e.en = en; e.fl = fl;
    e.hlt = hlt; e.cnt = cnt; e.chk_jpa = 1'b0; e.chk_evac = 1'b0;
    e.jpa = '0; e.evac = '0;
    return e;
  endfunction

  function automatic exp_t with_jpa(input exp_t e, input logic [15:0] a);
    exp_t r = e;
    r.chk_jpa = 1'b1; r.jpa = a;
    return r;
  endfunction

  function automatic exp_t with_evac(input exp_t e, input logic [15:0] a);
    exp_t r = e;
    r.chk_evac = 1'b1; r.evac = a;
    return r;
  endfunction

  task automatic drive(input stim_t s);
    bus.pc = s.pc; bus.imem_ready = s.imem_ready; bus.hazard_stall = s.hazard_stall;
    bus.halt_req = s.halt_req; bus.res_valid = s.res_valid; bus.res_pc = s.res_pc;
    bus.res_taken = s.res_taken; bus.res_target = s.res_target;
    bus.res_pred_taken = s.res_pred_taken; bus.res_pred_adr = s.res_pred_adr;
    bus.res_pcinc = s.res_pcinc;
  endtask

  // One cycle: drive just after the edge and queue the response for the monitor.
  task automatic step(input stim_t s, input exp_t e);
    @(posedge clk); #1;
    drive(s);
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(idle(16'h0000));
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".jump_pred"},          16'(bus.jump_pred),          16'(e.jp));
        check({e.name, ".jump_pred_miss"},     16'(bus.jump_pred_miss),     16'(e.jpm));
        check({e.name, ".jump_pred_adr_miss"}, 16'(bus.jump_pred_adr_miss), 16'(e.jpam));
        check({e.name, ".en_pc"},              16'(bus.en_pc),              16'(e.en));
        check({e.name, ".flush"},              16'(bus.flush),              16'(e.fl));
        check({e.name, ".halted"},             16'(bus.halted),             16'(e.hlt));
        check({e.name, ".miss_count"},         bus.miss_count,              e.cnt);
        if (e.chk_jpa)  check({e.name, ".jump_pred_adr"}, bus.jump_pred_adr, e.jpa);
        if (e.chk_evac) check({e.name, ".pcinc_evac"},    bus.pcinc_evac,    e.evac);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    reset = 1'b1;
    drive(idle(16'h0004));
    do_reset(2);

    //        name             jp jpm jpam en fl hlt cnt
    step(idle(16'h0004), mk("reset_idle", 0, 0, 0, 1, 0, 0, 16'd0));
    step(resolve(16'h0004, 16'h0010, 1, 16'h0040, 0, 16'h0000),
         with_evac(mk("amiss_alloc", 0, 0, 1, 1, 1, 0, 16'd0), 16'h0011));
    step(idle(16'h0010), with_jpa(mk("pred_new", 1, 0, 0, 1, 0, 0, 16'd1), 16'h0040));
    step(resolve(16'h0010, 16'h0010, 0, 16'h0011, 1, 16'h0040),
         with_evac(mk("pmiss", 0, 1, 0, 1, 1, 0, 16'd1), 16'h0011));
    step(resolve(16'h0010, 16'h0010, 0, 16'h0011, 0, 16'h0000),
         mk("weak_nt", 0, 0, 0, 1, 0, 0, 16'd2));
    step(resolve(16'h0010, 16'h0010, 0, 16'h0011, 0, 16'h0000),
         mk("ctr_at_min", 0, 0, 0, 1, 0, 0, 16'd2));
    step(idle(16'h0010), mk("ctr_sat_min", 0, 0, 0, 1, 0, 0, 16'd2));

    s = idle(16'h0020); s.hazard_stall = 1'b1;
    step(s, mk("stall_c1", 0, 0, 0, 0, 0, 0, 16'd2));
    s = resolve(16'h0020, 16'h0030, 1, 16'h0060, 0, 16'h0000); s.hazard_stall = 1'b1;
    step(s, mk("stall_c2_amiss", 0, 0, 1, 1, 1, 0, 16'd2));
    s = idle(16'h0020); s.hazard_stall = 1'b1;
    step(s, mk("stall_c3", 0, 0, 0, 0, 0, 0, 16'd3));
    step(idle(16'h0020), mk("stall_exit", 0, 0, 0, 0, 0, 0, 16'd3));
    step(idle(16'h0030), with_jpa(mk("run_after_stall", 1, 0, 0, 1, 0, 0, 16'd3), 16'h0060));
    s = idle(16'h0030); s.imem_ready = 1'b0;
    step(s, with_jpa(mk("imem_wait", 1, 0, 0, 0, 0, 0, 16'd3), 16'h0060));
    step(idle(16'h0030), mk("imem_exit", 1, 0, 0, 0, 0, 0, 16'd3));

    step(resolve(16'h0025, 16'h0025, 1, 16'h0040, 0, 16'h0000),
         mk("alloc_25", 0, 0, 1, 1, 1, 0, 16'd3));
    step(idle(16'h0025), with_jpa(mk("pred_25", 1, 0, 0, 1, 0, 0, 16'd4), 16'h0040));
    step(resolve(16'h0025, 16'h0025, 1, 16'h0050, 1, 16'h0040),
         mk("wrong_target", 0, 0, 1, 1, 1, 0, 16'd4));
    step(idle(16'h0025), with_jpa(mk("target_upd", 1, 0, 0, 1, 0, 0, 16'd5), 16'h0050));
    step(resolve(16'h0025, 16'h0025, 1, 16'h0050, 1, 16'h0050),
         with_jpa(mk("correct_pred", 1, 0, 0, 1, 0, 0, 16'd5), 16'h0050));

    s = resolve(16'h0025, 16'h0025, 1, 16'h0070, 1, 16'h0050); s.halt_req = 1'b1;
    step(s, mk("halt_with_miss", 0, 0, 0, 0, 1, 0, 16'd5));
    step(idle(16'h0025), mk("halted", 0, 0, 0, 0, 0, 1, 16'd5));
    step(resolve(16'h0025, 16'h0025, 0, 16'h0026, 1, 16'h0050),
         mk("halt_ignores_res", 0, 0, 0, 0, 0, 1, 16'd5));

    do_reset(1);
    step(idle(16'h0025), mk("post_reset", 0, 0, 0, 1, 0, 0, 16'd0));
    step(idle(16'h0030), mk("btb_cleared", 0, 0, 0, 1, 0, 0, 16'd0));
    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    wait (stim_done);
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: stimulus not done, expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Controls the fetch stage. Generates the pc enable, the branch prediction (from an internal direct-mapped BTB with 2-bit counters), the misprediction redirects and the pipeline flush.
- Compares the prediction carried down the pipe against the branch outcome resolved in MEM, then trains the BTB.
- Sits beside fetch and drives its jump_pred / jump_pred_adr / jump_pred_miss / jump_pred_adr_miss / pcinc_evac / en_pc inputs.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries; power of 2, minimum 2.
- IDX_W, $clog2(BTB_ENTRIES), BTB index width; index = pc[IDX_W-1:0], tag = pc[15:IDX_W].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pc  in  16  current fetch pc
- imem_ready  in  1  instruction memory returns data this cycle
- hazard_stall  in  1  decode load-use stall request
- halt_req  in  1  halt instruction reached MEM
- res_valid  in  1  a branch/jump is resolved in MEM this cycle
- res_pc  in  16  pc of the resolved branch
- res_taken  in  1  actual outcome
- res_target  in  16  actual target; equals ALUres_mem
- res_pred_taken  in  1  prediction carried with the instruction
- res_pred_adr  in  16  predicted target carried with the instruction
- res_pcinc  in  16  res_pc+1 carried with the instruction
- jump_pred  out  1  BTB predicts taken for pc
- jump_pred_adr  out  16  predicted target
- jump_pred_miss  out  1  predicted taken, actually not taken
- jump_pred_adr_miss  out  1  actually taken, and predicted not-taken or predicted the wrong target
- pcinc_evac  out  16  fall-through pc for jump_pred_miss
- en_pc  out  1  pc register enable
- flush  out  1  kill IF/ID, ID/EX and EX/MEM wrong-path entries
- halted  out  1  core halted
- miss_count  out  16  saturating misprediction counter

Behaviour:
- Reset state:
  - State RUN.
  - All BTB valid bits 0, counters 2'b00.
  - miss_count 0.
  - Outputs after reset: en_pc=1, all other outputs 0.
- Reset mid-operation discards pending stalls and misses; the next cycle is RUN.
- FSM states:
  - RUN to STALL when (hazard_stall or !imem_ready) and no miss.
  - STALL to RUN when both causes clear.
  - Any state to HALT on halt_req.
  - HALT is sticky until reset.
- Miss decode, evaluated combinationally when res_valid and state != HALT:
  - pmiss = res_pred_taken & !res_taken
  - amiss = res_taken & (!res_pred_taken | res_pred_adr != res_target)
  - pmiss and amiss are mutually exclusive.
- Miss outputs:
  - jump_pred_miss = pmiss, jump_pred_adr_miss = amiss, flush = pmiss|amiss, all in the same cycle.
  - pcinc_evac = res_pcinc, driven combinationally.
- Prediction:
  - hit = valid[idx] & tag match.
  - jump_pred = hit & ctr[idx][1] & !pmiss & !amiss & state != HALT.
  - The suppression on a miss is mandatory: fetch gives jump_pred priority over the miss inputs.
  - jump_pred_adr = target[idx] (don't-care when jump_pred=0).
- en_pc:
  - 1 on any miss, even while stalled; the redirect overrides the stall because the wrong path is flushed.
  - Otherwise 1 only in RUN with no stall cause.
  - Always 0 in HALT.
  - A miss in STALL returns the FSM to STALL or RUN according to the stall inputs.
- halt_req together with a miss: halt wins. No miss outputs, en_pc=0, flush=1.
- halted = (state == HALT).
- BTB update, on the clock edge when res_valid & state != HALT & !halt_req:
  - Entry hit on res_pc:
    - ctr saturating +1 if taken, -1 if not.
    - target <= res_target if taken.
  - Entry miss and taken: allocate (valid=1, tag, target=res_target, ctr=2'b10).
  - Entry miss and not taken: no write.
  - Read and write to the same index in one cycle: lookup sees the old contents.
- miss_count increments on pmiss|amiss and saturates at 16'hFFFF.
- Arithmetic is 16-bit unsigned; the module performs no pc arithmetic.

Decomposition:
- Shared package (core_pkg):
  - typedef of the FSM state enum (RUN, STALL, HALT)
  - typedef of the 2-bit counter plus SAT_MAX/SAT_MIN constants
  - typedef of the BTB entry struct (valid, tag, target, ctr)
  - XLEN=16
- One sub-module: btb, holding storage, lookup and update. fetch_ctrl holds the FSM, miss decode and counter.

Test Plan:
- Reset, pc=16'h0004, no res_valid -> jump_pred=0, en_pc=1, flush=0, miss_count=0.
- Resolve res_pc=16'h0010, taken, target 16'h0040, pred_taken=0 -> jump_pred_adr_miss=1, flush=1, en_pc=1. Next cycle pc=16'h0010 -> jump_pred=1, jump_pred_adr=16'h0040.
- Entry from the previous scenario with ctr=2'b10; resolve not-taken with pred_taken=1, res_pcinc=16'h0011 -> jump_pred_miss=1, pcinc_evac=16'h0011, jump_pred=0 that cycle. After a second not-taken resolve, pc=16'h0010 -> jump_pred=0.
- hazard_stall=1 for 3 cycles -> en_pc=0 for 3 cycles. An amiss injected in cycle 2 -> en_pc=1 and flush=1 in that cycle only.
- Predicted taken to 16'h0040, actual taken to 16'h0050 -> jump_pred_adr_miss=1; the BTB target becomes 16'h0050.
- halt_req together with an amiss -> no miss outputs, en_pc=0, halted=1 from the next cycle, BTB unchanged. Then reset -> state RUN, halted=0.
